// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, width helper and parameter checks for the FIFO family
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV
`define FIFO_CHECK_DEPTH(d) if ((d) < 4 || ((d) & ((d) - 1)) != 0) begin : g_bad_depth $error("FIFO_DEPTH must be a power of two >= 4"); end
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage
`endif

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port storage, synchronous write, asynchronous read by index
//   clk, we, waddr, wdata : write port
//   raddr, rdata          : combinational read port
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_prog_sync.sv
// fifo_prog_sync: single-clock FIFO with programmable thresholds, count, error pulses, optional FWFT
//   clk, rstN                   : clock, async active-low reset
//   wr_en, data_in              : write side
//   rd_en, data_out             : read side
//   af_thresh, ae_thresh        : almost-full / almost-empty thresholds
//   empty, full, almost_full, almost_empty, count : registered status
//   overflow, underflow         : one-cycle error pulses
module fifo_prog_sync
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int FWFT       = 0
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             wr_en,
  input  logic [FIFO_WIDTH-1:0]            data_in,
  input  logic                             rd_en,
  input  logic [fifo_cw(FIFO_DEPTH)-1:0]   af_thresh,
  input  logic [fifo_cw(FIFO_DEPTH)-1:0]   ae_thresh,
  output logic [FIFO_WIDTH-1:0]            data_out,
  output logic                             empty,
  output logic                             full,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [fifo_cw(FIFO_DEPTH)-1:0]   count,
  output logic                             overflow,
  output logic                             underflow
);
  localparam int CW = fifo_cw(FIFO_DEPTH);
  localparam int AW = CW - 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  `FIFO_CHECK_DEPTH(FIFO_DEPTH)
  logic [CW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [FIFO_WIDTH-1:0] head, dout_q;
  logic wr_acc, rd_acc, af_q, rst_pend;
  always_comb begin
    wr_acc = wr_en && (!full || rd_en);
    rd_acc = rd_en && !empty;
    wr_ptr_nxt = wr_ptr + CW'(wr_acc);
    rd_ptr_nxt = rd_ptr + CW'(rd_acc);
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end
  fifo_mem #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      af_q <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
      dout_q <= '0;
      rst_pend <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty <= count_nxt == '0;
      full <= count_nxt == CW'(FIFO_DEPTH);
      af_q <= count_nxt >= af_thresh;
      almost_empty <= count_nxt <= ae_thresh;
      overflow <= wr_en && full && !rd_en;
      underflow <= rd_en && empty;
      dout_q <= rd_acc ? head : dout_q;
      rst_pend <= 1'b0;
    end
  // Pointers span twice the depth, so their difference is the exact occupancy.
  assign count = wr_ptr - rd_ptr;
  // Until the first edge after reset, almost_full reflects a zero threshold live
  // against the empty state, avoiding a reset value that depends on an input.
  assign almost_full = rst_pend ? (af_thresh == '0) : af_q;
  // The popped head is what dout_q captures, so FWFT falls back to it when empty.
  assign data_out = (MODE == FIFO_FWFT && !empty) ? head : dout_q;
endmodule

// File: tb/tb_fifo_prog_sync.sv
// tb_fifo_prog_sync: self-checking bench for fifo_prog_sync (standard and FWFT instances)
module tb_fifo_prog_sync;
  localparam int W = 32;
  localparam int D = 32;
  localparam int CW = 6;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [W-1:0] data_in = '0, f_din = '0, data_out, f_dout;
  logic [CW-1:0] af_thresh = 6'd28, ae_thresh = 6'd3, count, f_count;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  int nchk = 0, nerr = 0;
  logic [W-1:0] model[$], expq[$];
  logic [W-1:0] exp_dout = '0;
  typedef struct {
    logic w;
    logic r;
    logic [W-1:0] d;
    int cnt;
    logic [W-1:0] dout;
    logic unf;
  } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) dut (
    .clk(clk), .rstN(rstN), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(data_out),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) dut_f (
    .clk(clk), .rstN(rstN), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(f_dout),
    .empty(f_empty), .full(f_full), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    int sz;
    logic e_ovf, e_unf;
    sz = model.size();
    e_ovf = w && sz == D && !r;
    e_unf = r && sz == 0;
    if (r && sz > 0) expq.push_back(model.pop_front());
    if (w && (sz < D || r)) model.push_back(d);
    wr_en = w;
    data_in = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("count", count, model.size());
    chk("empty", empty, model.size() == 0);
    chk("full", full, model.size() == D);
    chk("almost_full", almost_full, model.size() >= int'(af_thresh));
    chk("almost_empty", almost_empty, model.size() <= int'(ae_thresh));
    chk("overflow", overflow, e_ovf);
    chk("underflow", underflow, e_unf);
    if (expq.size() > 0) exp_dout = expq.pop_front();
    chk("data_out", data_out, exp_dout);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h11, 1, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h22, 2, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0, 1, 32'h11, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h33, 1, 32'h22, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 0, 32'h33, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 0, 32'h33, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'h44, 1, 32'h33, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 0, 32'h44, 1'b0};
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    af_thresh = 6'd0;
    #1;
    chk("rst_af_zero_thresh", almost_full, 1);
    af_thresh = 6'd28;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_dout", data_out, tbl[i].dout);
      chk("tbl_unf", underflow, tbl[i].unf);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i, 1'b0);
      if (i == 26) chk("af_before_28", almost_full, 0);
      if (i == 27) chk("af_at_28", almost_full, 1);
      if (i == 2) chk("ae_at_3", almost_empty, 1);
      if (i == 3) chk("ae_at_4", almost_empty, 0);
    end
    step(1'b1, 32'hDEAD, 1'b0);
    chk("ovf_pulse", overflow, 1);
    step(1'b0, 0, 1'b0);
    chk("ovf_single", overflow, 0);
    for (int i = 0; i < 32; i++) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("unf_pulse", underflow, 1);
    chk("dout_hold_31", data_out, 31);
    for (int i = 0; i < 32; i++) step(1'b1, 100 + i, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 200 + i, 1'b1);
    chk("full_rw_count", count, 32);
    af_thresh = 6'd63;
    ae_thresh = 6'd40;
    step(1'b0, 0, 1'b0);
    chk("big_af", almost_full, 0);
    chk("big_ae", almost_empty, 1);
    af_thresh = 6'd28;
    ae_thresh = 6'd3;
    for (int i = 0; i < 15; i++) step(1'b1 == 1'b0, 0, 1'b1);
    chk("pre_rst_count", count, 17);
    #3;
    rstN = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_ae", almost_empty, 1);
    chk("mid_rst_dout", data_out, 0);
    model.delete();
    expq.delete();
    exp_dout = '0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(1'b1, 32'h5A5A, 1'b0);
    step(1'b0, 0, 1'b1);
    chk("post_rst_data", data_out, 32'h5A5A);
    f_din = 32'hA5;
    f_wr = 1'b1;
    @(posedge clk);
    #1;
    f_wr = 1'b0;
    chk("fwft_dout", f_dout, 32'hA5);
    chk("fwft_empty", f_empty, 0);
    chk("fwft_count", f_count, 1);
    chk("fwft_full", f_full, 0);
    chk("fwft_af", f_af, 0);
    chk("fwft_ae", f_ae, 1);
    @(posedge clk);
    #1;
    chk("fwft_dout_idle", f_dout, 32'hA5);
    f_rd = 1'b1;
    @(posedge clk);
    #1;
    chk("fwft_empty_after_rd", f_empty, 1);
    chk("fwft_dout_hold", f_dout, 32'hA5);
    chk("fwft_unf_none", f_unf, 0);
    @(posedge clk);
    #1;
    f_rd = 1'b0;
    chk("fwft_unf", f_unf, 1);
    chk("fwft_ovf", f_ovf, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
